// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared VGA raster constants and coordinate type. The default
//            640x480 @ 60 Hz timing lives here. The coordinate type is used
//            by the timing generator and by the colour stage it feeds.
// Contents : H_/V_ ACTIVE, FP, SYNC, BP, TOTAL; COORD_W; COORD_MAX; coord_t
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int COORD_W   = 10;
    // Largest raster dimension that a coordinate can still count through.
    localparam int COORD_MAX = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/pix_en_div.sv
`default_nettype none
// ============================================================================
// Module   : pix_en_div
// Purpose  : Pixel-rate strobe generator. A counter runs 0..CLK_DIV-1 and
//            wraps. The strobe is high on the last count, giving one
//            clk-wide pulse every CLK_DIV clocks. With CLK_DIV=1 the strobe
//            is high on every cycle once reset is released.
// Ports    : clk_i    - system clock
//            rst_ni   - asynchronous active-low reset
//            pix_en_o - pixel-enable strobe, decoded from the counter
// Revision : 1.0 - initial release
// ============================================================================
module pix_en_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic pix_en_o
);

    // A one-bit counter is kept even for CLK_DIV=1. It then simply stays at 0.
    localparam int C_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(CLK_DIV - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    generate
        if (CLK_DIV < 1) begin : g_bad_clk_div
            $error("pix_en_div: CLK_DIV must be >= 1");
        end
    endgenerate

    logic [C_CNT_W-1:0] div_cnt_q;
    logic [C_CNT_W-1:0] div_cnt_d;

    always_comb begin
        div_cnt_d = (div_cnt_q == C_CNT_LAST) ? '0 : div_cnt_q + C_CNT_ONE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign pix_en_o = (div_cnt_q == C_CNT_LAST);

endmodule : pix_en_div
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : VGA raster timing generator. It provides the pixel-enable
//            strobe, the horizontal and vertical counters, a blanking flag,
//            hsync/vsync and a frame-start pulse. Every decode is registered
//            from the next-state counter values. Each decode therefore
//            changes on the same clk edge as the coordinates it describes.
// Ports    : clk         - system clock (50 MHz)
//            reset_n     - asynchronous active-low reset
//            pix_en      - one-clk strobe; counters advance when it is high
//            xcoord      - pixel counter, 0..H_TOTAL-1
//            ycoord      - line counter, 0..V_TOTAL-1
//            nocolor     - 1 while blanking (outside the visible area)
//            hsync       - horizontal sync, asserted level SYNC_POL
//            vsync       - vertical sync, asserted level SYNC_POL
//            frame_start - one-clk pulse when the raster enters (0,0)
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int CLK_DIV  = 2,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    output logic                        pix_en,
    output logic [vga_pkg::COORD_W-1:0] xcoord,
    output logic [vga_pkg::COORD_W-1:0] ycoord,
    output logic                        nocolor,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        frame_start
);

    import vga_pkg::*;

    localparam int C_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int C_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int C_HS_START = H_ACTIVE + H_FP;
    localparam int C_HS_END   = C_HS_START + H_SYNC;
    localparam int C_VS_START = V_ACTIVE + V_FP;
    localparam int C_VS_END   = C_VS_START + V_SYNC;

    localparam coord_t C_X_LAST = coord_t'(C_H_TOTAL - 1);
    localparam coord_t C_Y_LAST = coord_t'(C_V_TOTAL - 1);
    localparam coord_t C_ONE    = coord_t'(1);

    generate
        if ((C_H_TOTAL > COORD_MAX) || (C_V_TOTAL > COORD_MAX)) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed coordinate range");
        end
    endgenerate

    pix_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_en_div (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .pix_en_o (pix_en)
    );

    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   nocolor_q, nocolor_d;
    logic   hsync_q, hsync_d;
    logic   vsync_q, vsync_d;
    logic   frame_start_q, frame_start_d;

    // Raster counters. Reset parks them on the last pixel of the frame, so
    // the first strobe after release wraps them to (0,0).
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_en) begin
            if (x_q == C_X_LAST) begin
                x_d = '0;
                y_d = (y_q == C_Y_LAST) ? '0 : y_q + C_ONE;
            end else begin
                x_d = x_q + C_ONE;
            end
        end
    end

    // Decode from the next-state counters, so the registered flags line up
    // with the coordinates they describe.
    always_comb begin
        nocolor_d     = (int'(x_d) >= H_ACTIVE) || (int'(y_d) >= V_ACTIVE);
        hsync_d       = ((int'(x_d) >= C_HS_START) && (int'(x_d) < C_HS_END))
                        ? SYNC_POL : ~SYNC_POL;
        vsync_d       = ((int'(y_d) >= C_VS_START) && (int'(y_d) < C_VS_END))
                        ? SYNC_POL : ~SYNC_POL;
        // Gated by pix_en so the held (0,0) cycles do not repeat the pulse.
        frame_start_d = pix_en && (x_d == '0) && (y_d == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q           <= C_X_LAST;
            y_q           <= C_Y_LAST;
            nocolor_q     <= 1'b1;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            nocolor_q     <= nocolor_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign xcoord      = x_q;
    assign ycoord      = y_q;
    assign nocolor     = nocolor_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule : vga_timing_gen
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480 @ 60 Hz VGA raster timing: pixel-enable strobe, horizontal/vertical counters, blanking flag and sync pulses.
Drives the xcoord/ycoord/nocolor inputs of the colour stage that paints the game quadrants, and drives hsync/vsync to the connector.
The colour stage's RGB is registered downstream on pix_en so it stays aligned with the syncs.
Runs from the 50 MHz board clock, with a divide-by-CLK_DIV pixel enable; there is no derived clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, clk cycles per pixel (>=1)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
pix_en  out  1  one-clk strobe; counters advance on clk edges where pix_en=1
xcoord  out  10  horizontal pixel counter, 0..H_TOTAL-1
ycoord  out  10  vertical line counter, 0..V_TOTAL-1
nocolor  out  1  1 = blanking; the colour stage must output black
hsync  out  1  horizontal sync to connector
vsync  out  1  vertical sync to connector
frame_start  out  1  one-clk pulse when the raster enters (0,0)

Behaviour:
- Derived constants: H_TOTAL = 800 and V_TOTAL = 525 at defaults. Elaboration error if either exceeds 1024 or CLK_DIV < 1.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en = (div_cnt == CLK_DIV-1). It is combinational from the register.
  - With CLK_DIV=1, pix_en is constantly 1 out of reset.
- Counters:
  - On each clk edge with pix_en=1, xcoord increments.
  - At xcoord == H_TOTAL-1, xcoord wraps to 0 and ycoord increments on the same edge.
  - At ycoord == V_TOTAL-1 together with xcoord wrap, ycoord wraps to 0.
  - Counters hold when pix_en=0.
- Decodes: nocolor, hsync, vsync and frame_start are registered. Each is computed from the next counter values, so it is valid in the same cycle as the xcoord/ycoord it describes, with zero relative skew.
  - nocolor = 1 iff xcoord >= H_ACTIVE or ycoord >= V_ACTIVE.
  - hsync = SYNC_POL iff H_ACTIVE+H_FP <= xcoord < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults); otherwise ~SYNC_POL.
  - vsync = SYNC_POL iff V_ACTIVE+V_FP <= ycoord < V_ACTIVE+V_FP+V_SYNC (490..491 at defaults), for whole lines; otherwise ~SYNC_POL.
  - frame_start = 1 for exactly the clk cycle in which (xcoord, ycoord) first equals (0,0); 0 otherwise, including the held (0,0) cycles while pix_en=0.
- Reset (asynchronous, immediate, including mid-frame):
  - div_cnt = 0, xcoord = H_TOTAL-1, ycoord = V_TOTAL-1, nocolor = 1.
  - hsync = vsync = ~SYNC_POL (deasserted), frame_start = 0.
  - The first pix_en after release wraps the counters to (0,0) and pulses frame_start, so every frame starts cleanly.
- Reset release is assumed synchronised upstream; no internal synchroniser.
- Frame period = H_TOTAL*V_TOTAL*CLK_DIV clk = 840000 clk at defaults (16.8 ms).

Decomposition:
- Package vga_pkg holds:
  - the default timing localparams (H_/V_ ACTIVE, FP, SYNC, BP and TOTAL);
  - COORD_W = 10;
  - a coord_t typedef (logic [COORD_W-1:0]), shared with the colour stage.
- One sub-module, pix_en_div: the parameterised CLK_DIV strobe generator, reusable for any later pixel-rate logic.
- Counters and sync decode stay in vga_timing_gen.

Test Plan:
- Assert reset_n=0 mid-frame at (300,200) -> outputs change with no clk edge: xcoord=799, ycoord=524, nocolor=1, hsync=vsync=1, frame_start=0. Release -> 2 clk later (0,0), nocolor=0, frame_start=1 for 1 clk only.
- Line timing, CLK_DIV=2 -> pix_en every 2nd clk. nocolor=1 exactly for xcoord 640..799 on an active line. hsync=0 exactly for xcoord 656..751 (192 clk). Line period 1600 clk.
- Line wrap -> on the edge xcoord 799→0, ycoord 10→11. nocolor falls on the same edge and hsync is 1.
- Frame timing -> vsync=0 exactly while ycoord is 490..491 (3200 clk), with hsync still toggling. nocolor=1 for all of ycoord 480..524.
- Frame wrap -> (799,524)→(0,0) with frame_start pulse. Consecutive frame_start pulses exactly 840000 clk apart over 3 frames.
- CLK_DIV=1, SYNC_POL=1 variant -> pix_en constantly 1, frame period 420000 clk, hsync=1 only for xcoord 656..751.
